// File: rtl/pwl_slope_packer.sv
// pwl_slope_packer: turns a stream of (delta, sample) waypoints into
// {time, sample, slope} words for a piecewise-linear generator.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data             {delta[2W-1:W] unsigned, sample[W-1:0] signed}
//   in_valid/in_ready   waypoint handshake; in_last marks the final one
//   out_data            {time, sample, slope} of the previous waypoint
//   out_valid/out_ready word handshake; out_done flags the final word
//   err_dt_zero         sticky: a non-first waypoint had delta 0
//   err_time_ovf        sticky: absolute time wrapped
module pwl_slope_packer #(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2*SAMPLE_WIDTH-1:0] in_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [3*SAMPLE_WIDTH-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_done,
    output logic                      err_dt_zero,
    output logic                      err_time_ovf
);

    localparam int W  = SAMPLE_WIDTH;
    localparam int CW = $clog2(W + 3);

    // W+1 quotient steps, one sign/saturate step, then hand over to EMIT.
    localparam logic [CW-1:0] STEP_END = CW'(W + 1);
    localparam logic [CW-1:0] EMIT_AT  = CW'(W + 2);

    localparam logic [W:0] POS_MAX = {2'b00, {(W-1){1'b1}}};
    localparam logic [W:0] NEG_MAG = {2'b01, {(W-1){1'b0}}};
    localparam logic [W-1:0] SLOPE_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        DIVIDE,
        EMIT,
        EMIT_LAST
    } state_t;

    state_t state, state_nx;

    logic          active;
    logic [W-1:0]  prev_time, prev_sample;
    logic [W-1:0]  cur_time, cur_sample;
    logic          cur_last;
    logic [W-1:0]  dt_q;
    logic          dt_zero;
    logic          dv_neg;
    logic [W:0]    mag, rem, quo;
    logic [CW-1:0] cnt;
    logic [W-1:0]  slope;
    logic          dtz_flag, ovf_flag;

    logic [W-1:0]  in_sample, in_delta;
    logic          accept;
    logic [W:0]    dv, dv_mag, t_sum;
    logic [W:0]    trial, quo_neg;
    logic          fits;
    logic [W-1:0]  sat;

    assign in_sample = in_data[W-1:0];
    assign in_delta  = in_data[2*W-1:W];
    assign accept    = in_valid && in_ready;

    assign dv     = {in_sample[W-1], in_sample} - {prev_sample[W-1], prev_sample};
    assign dv_mag = dv[W] ? -dv : dv;
    assign t_sum  = {1'b0, prev_time} + {1'b0, in_delta};

    // Restoring divide: bring in the next dividend bit, subtract if it fits.
    assign trial   = {rem[W-1:0], mag[W]};
    assign fits    = trial >= {1'b0, dt_q};
    assign quo_neg = -quo;

    always_comb begin
        sat = '0;
        if (dv_neg) begin
            sat = (quo >= NEG_MAG) ? SLOPE_MIN : quo_neg[W-1:0];
        end else begin
            sat = (quo > POS_MAX) ? POS_MAX[W-1:0] : quo[W-1:0];
        end
    end

    assign err_dt_zero  = dtz_flag;
    assign err_time_ovf = ovf_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_done  = 1'b0;
        out_data  = '0;
        unique case (state)
            IDLE: begin
                in_ready = active;
                if (in_valid && active) begin
                    state_nx = in_last ? EMIT_LAST : HOLD;
                end
            end
            HOLD: begin
                in_ready = active;
                if (in_valid && active) begin
                    state_nx = DIVIDE;
                end
            end
            DIVIDE: begin
                if (cnt == EMIT_AT) begin
                    state_nx = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_data  = {prev_time, prev_sample, slope};
                if (out_ready) begin
                    state_nx = cur_last ? EMIT_LAST : HOLD;
                end
            end
            EMIT_LAST: begin
                out_valid = 1'b1;
                out_done  = 1'b1;
                out_data  = {prev_time, prev_sample, {W{1'b0}}};
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active      <= 1'b0;
            prev_time   <= '0;
            prev_sample <= '0;
            cur_time    <= '0;
            cur_sample  <= '0;
            cur_last    <= 1'b0;
            dt_q        <= '0;
            dt_zero     <= 1'b0;
            dv_neg      <= 1'b0;
            mag         <= '0;
            rem         <= '0;
            quo         <= '0;
            cnt         <= '0;
            slope       <= '0;
            dtz_flag    <= 1'b0;
            ovf_flag    <= 1'b0;
        end else begin
            // Holds in_ready low until the first edge after reset release.
            active <= 1'b1;

            if (state == IDLE && accept) begin
                prev_sample <= in_sample;
                prev_time   <= '0;
            end

            if (state == HOLD && accept) begin
                cur_sample <= in_sample;
                cur_time   <= t_sum[W-1:0];
                cur_last   <= in_last;
                dt_q       <= in_delta;
                dt_zero    <= (in_delta == '0);
                dv_neg     <= dv[W];
                mag        <= dv_mag;
                rem        <= '0;
                quo        <= '0;
                cnt        <= '0;
                if (t_sum[W]) begin
                    ovf_flag <= 1'b1;
                end
                if (in_delta == '0) begin
                    dtz_flag <= 1'b1;
                end
            end

            // A zero delta still walks the full count so latency is fixed;
            // its garbage quotient is replaced by 0 at the sign step.
            if (state == DIVIDE) begin
                cnt <= cnt + CW'(1);
                if (cnt < STEP_END) begin
                    mag <= {mag[W-1:0], 1'b0};
                    rem <= fits ? (trial - {1'b0, dt_q}) : trial;
                    quo <= {quo[W-1:0], fits};
                end else if (cnt == STEP_END) begin
                    slope <= dt_zero ? '0 : sat;
                end
            end

            if (state == EMIT && out_ready) begin
                prev_time   <= cur_time;
                prev_sample <= cur_sample;
            end

            if (state == EMIT_LAST && out_ready) begin
                prev_time <= '0;
            end
        end
    end

endmodule
